mp3_serializer: RTL and testbench

Byte-to-serial transmitter driving the MP3 decoder's serial data input (mp3_clk / mp3_sync / mp3_data, flow-controlled by the decoder's mp3_req). It sits between the MP3/SD DMA byte stream and the decoder pins. It accepts bytes over a valid/ready handshake and shifts them out MSB-first, one sync-marked byte at a time. It never starts a byte while the decoder's request is low.

---
 rtl/mp3_serializer.sv | 179 +++++++++++++++++
 tb/tb_mp3_serializer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_serializer.sv
// Byte-to-serial transmitter for the MP3 decoder serial input: a one-byte holding
// register feeds an MSB-first shifter gated by the synchronized decoder request.
module mp3_serializer #(
    parameter int DIV = 2,
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mp3_req,
    output logic       mp3_clk,
    output logic       mp3_sync,
    output logic       mp3_data,
    output logic       busy
);

    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIT_LO = 2'd1,
        ST_BIT_HI = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          req_meta_q, req_s_q;
    logic          mp3_clk_q, mp3_clk_d;
    logic          mp3_sync_q, mp3_sync_d;
    logic          mp3_data_q, mp3_data_d;
    logic          busy_q, busy_d;

    logic          accept_s;
    logic          start_s;
    logic          cnt_done_s;

    assign in_ready   = !hold_full_q;
    assign mp3_clk    = mp3_clk_q;
    assign mp3_sync   = mp3_sync_q;
    assign mp3_data   = mp3_data_q;
    assign busy       = busy_q;

    // hold_full blocks accept, so accept and an IDLE load never coincide
    assign accept_s   = in_valid && !hold_full_q;
    assign start_s    = (state_q == ST_IDLE) && hold_full_q && req_s_q;
    assign cnt_done_s = (cnt_q == CNT_ZERO);

    // Two-flop synchronizer for the decoder request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= mp3_req;
            req_s_q    <= req_meta_q;
        end
    end

    // Holding register: filled by the handshake, emptied when the shifter loads
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept_s) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end else if (start_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Serial sequencer: data/sync move only with the mp3_clk fall or the byte start
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        sh_d       = sh_q;
        mp3_clk_d  = mp3_clk_q;
        mp3_sync_d = mp3_sync_q;
        mp3_data_d = mp3_data_q;
        case (state_q)
            ST_IDLE: begin
                mp3_clk_d = 1'b0;
                if (start_s) begin
                    state_d    = ST_BIT_LO;
                    sh_d       = {hold_q[6:0], 1'b0};
                    bitcnt_d   = 3'd7;
                    cnt_d      = DIV_LOAD;
                    mp3_data_d = hold_q[7];
                    mp3_sync_d = 1'b1;
                end else begin
                    mp3_sync_d = 1'b0;
                end
            end
            ST_BIT_LO: begin
                if (cnt_done_s) begin
                    state_d   = ST_BIT_HI;
                    mp3_clk_d = 1'b1;
                    cnt_d     = DIV_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_BIT_HI: begin
                if (cnt_done_s) begin
                    mp3_clk_d  = 1'b0;
                    mp3_sync_d = 1'b0;
                    if (bitcnt_q != 3'd0) begin
                        state_d    = ST_BIT_LO;
                        bitcnt_d   = bitcnt_q - 3'd1;
                        mp3_data_d = sh_q[7];
                        sh_d       = {sh_q[6:0], 1'b0};
                        cnt_d      = DIV_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mp3_clk_d  = 1'b0;
                mp3_sync_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            bitcnt_q    <= 3'd0;
            sh_q        <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            mp3_clk_q   <= 1'b0;
            mp3_sync_q  <= 1'b0;
            mp3_data_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            mp3_clk_q   <= mp3_clk_d;
            mp3_sync_q  <= mp3_sync_d;
            mp3_data_q  <= mp3_data_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mp3_serializer.sv
// Directed bench for mp3_serializer: instance a uses DIV=2/GAP=4, instance b uses
// DIV=1/GAP=3 for a long randomized stream with a decoder-style request model.
module tb_mp3_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] a_in_data = 8'h00;
    logic       a_in_valid = 1'b0;
    logic       a_mp3_req = 1'b1;
    logic       a_in_ready, a_mp3_clk, a_mp3_sync, a_mp3_data, a_busy;

    logic [7:0] b_in_data = 8'h00;
    logic       b_in_valid = 1'b0;
    logic       b_mp3_req = 1'b1;
    logic       b_in_ready, b_mp3_clk, b_mp3_sync, b_mp3_data, b_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // receiver state for instance a
    int         a_nb = 0, a_stray = 0, a_stab = 0, a_sync_rises = 0;
    logic [7:0] a_sh = 8'h00;
    logic       a_pclk = 1'b0, a_psync = 1'b0, a_pdata = 1'b0;
    int         a_rise_t[$];
    int         a_sync_t[$];
    logic [7:0] a_rx[$];

    // receiver state for instance b
    int         b_nb = 0, b_stray = 0, b_stab = 0, b_viol = 0;
    logic [7:0] b_sh = 8'h00;
    logic       b_pclk = 1'b0, b_psync = 1'b0, b_pdata = 1'b0;
    logic [2:0] b_hist = 3'b111;
    logic [7:0] b_rx[$];
    logic [7:0] b_exp[$];
    bit         b_feed_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mp3_serializer #(.DIV(2), .GAP(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mp3_req(a_mp3_req), .mp3_clk(a_mp3_clk), .mp3_sync(a_mp3_sync),
        .mp3_data(a_mp3_data), .busy(a_busy)
    );

    mp3_serializer #(.DIV(1), .GAP(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mp3_req(b_mp3_req), .mp3_clk(b_mp3_clk), .mp3_sync(b_mp3_sync),
        .mp3_data(b_mp3_data), .busy(b_busy)
    );

    // Decoder-side receiver for a: samples on each observed mp3_clk rise
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            a_nb = 0; a_pclk = 1'b0; a_psync = 1'b0; a_pdata = 1'b0;
        end else begin
            if (a_mp3_clk && (a_mp3_data !== a_pdata || a_mp3_sync !== a_psync)) a_stab++;
            if (a_mp3_clk && !a_pclk) begin
                a_rise_t.push_back(cyc);
                if (a_mp3_sync) begin
                    if (a_nb != 0) a_stray++;
                    a_sh = {7'd0, a_mp3_data};
                    a_nb = 1;
                    a_sync_rises++;
                end else if (a_nb == 0) begin
                    a_stray++;
                end else begin
                    a_sh = {a_sh[6:0], a_mp3_data};
                    a_nb++;
                end
                if (a_nb == 8) begin
                    a_rx.push_back(a_sh);
                    a_nb = 0;
                end
            end
            if (a_mp3_sync && !a_psync) a_sync_t.push_back(cyc);
            a_pclk = a_mp3_clk; a_psync = a_mp3_sync; a_pdata = a_mp3_data;
        end
    end

    // Decoder-side receiver for b, also flagging byte starts after a long req low
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            b_nb = 0; b_pclk = 1'b0; b_psync = 1'b0; b_pdata = 1'b0; b_hist = 3'b111;
        end else begin
            b_hist = {b_hist[1:0], b_mp3_req};
            if (b_mp3_clk && (b_mp3_data !== b_pdata || b_mp3_sync !== b_psync)) b_stab++;
            if (b_mp3_sync && !b_psync && b_hist == 3'b000) b_viol++;
            if (b_mp3_clk && !b_pclk) begin
                if (b_mp3_sync) begin
                    if (b_nb != 0) b_stray++;
                    b_sh = {7'd0, b_mp3_data};
                    b_nb = 1;
                end else if (b_nb == 0) begin
                    b_stray++;
                end else begin
                    b_sh = {b_sh[6:0], b_mp3_data};
                    b_nb++;
                end
                if (b_nb == 8) begin
                    b_rx.push_back(b_sh);
                    b_nb = 0;
                end
            end
            b_pclk = b_mp3_clk; b_psync = b_mp3_sync; b_pdata = b_mp3_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        int toggles;
        @(negedge clk);
        #2;
        a_in_data = 8'($urandom); a_in_valid = 1'($urandom); a_mp3_req = 1'($urandom);
        b_in_data = 8'($urandom); b_in_valid = 1'($urandom); b_mp3_req = 1'($urandom);
        rst_n = 1'b0;
        #1;
        checks++; if (a_mp3_clk !== 1'b0) begin failures++; $display("FAIL reset_clk: got %b expected 0", a_mp3_clk); end
        checks++; if (a_mp3_sync !== 1'b0) begin failures++; $display("FAIL reset_sync: got %b expected 0", a_mp3_sync); end
        checks++; if (a_mp3_data !== 1'b0) begin failures++; $display("FAIL reset_data: got %b expected 0", a_mp3_data); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (b_mp3_clk !== 1'b0 || b_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_b: got clk=%b ready=%b expected clk=0 ready=1", b_mp3_clk, b_in_ready);
        end
        toggles = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_mp3_clk !== 1'b0 || b_mp3_clk !== 1'b0 || a_busy !== 1'b0) toggles++;
        end
        checks++; if (toggles != 0) begin failures++; $display("FAIL reset_hold: got %0d active cycles expected 0", toggles); end
        a_in_valid = 1'b0; a_mp3_req = 1'b1;
        b_in_valid = 1'b0; b_mp3_req = 1'b1;
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            failures++; $display("FAIL post_reset: got ready=%b busy=%b expected ready=1 busy=0", a_in_ready, a_busy);
        end
    endtask

    task automatic test_single;
        int base_r, base_s, base_rx, acc, bnd, bad_sp;
        base_r = a_rise_t.size(); base_s = a_sync_rises; base_rx = a_rx.size();
        @(negedge clk);
        a_in_data = 8'hA5; a_in_valid = 1'b1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", a_in_ready); end
        @(posedge clk); #1;
        acc = cyc; a_in_valid = 1'b0;
        bnd = 0;
        while ((a_rx.size() == base_rx || a_busy) && bnd < 300) begin @(negedge clk); bnd++; end
        repeat (4) @(negedge clk);
        checks++; if (a_rx.size() != base_rx + 1) begin
            failures++; $display("FAIL single_count: got %0d bytes expected 1", a_rx.size() - base_rx);
        end else begin
            checks++; if (a_rx[base_rx] !== 8'hA5) begin failures++; $display("FAIL single_byte: got %h expected a5", a_rx[base_rx]); end
        end
        checks++; if (a_rise_t.size() - base_r != 8) begin
            failures++; $display("FAIL single_rises: got %0d expected 8", a_rise_t.size() - base_r);
        end else begin
            bad_sp = 0;
            for (int j = base_r + 1; j < base_r + 8; j++) if (a_rise_t[j] - a_rise_t[j-1] != 4) bad_sp++;
            checks++; if (bad_sp != 0) begin failures++; $display("FAIL single_spacing: got %0d gaps not 4 cycles expected 0", bad_sp); end
            checks++; if (a_rise_t[base_r] - a_sync_t[a_sync_t.size()-1] != 2) begin
                failures++; $display("FAIL single_first_rise: got %0d cycles after sync expected 2", a_rise_t[base_r] - a_sync_t[a_sync_t.size()-1]);
            end
        end
        checks++; if (a_sync_rises - base_s != 1) begin
            failures++; $display("FAIL single_sync_rises: got %0d rises with sync expected 1", a_sync_rises - base_s);
        end
        // accept edge, then the IDLE load edge: sync seen in the second cycle after the accept cycle
        checks++; if (a_sync_t[a_sync_t.size()-1] - acc != 1) begin
            failures++; $display("FAIL single_latency: got %0d expected 1 edge after accept edge", a_sync_t[a_sync_t.size()-1] - acc);
        end
        checks++; if (a_stab != 0 || a_stray != 0) begin
            failures++; $display("FAIL single_protocol: got stab=%0d stray=%0d expected 0", a_stab, a_stray);
        end
    endtask

    task automatic test_stream;
        logic [7:0] v[4];
        int base_rx, base_s, bnd;
        v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h5A; v[3] = 8'h3C;
        base_rx = a_rx.size(); base_s = a_sync_t.size();
        @(negedge clk);
        a_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = v[i];
            bnd = 0;
            while (!a_in_ready && bnd < 500) begin @(negedge clk); bnd++; end
            @(negedge clk);
            checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL stream_ready_drop%0d: got %b expected 0", i, a_in_ready); end
        end
        a_in_valid = 1'b0;
        bnd = 0;
        while ((a_rx.size() < base_rx + 4 || a_busy) && bnd < 1000) begin @(negedge clk); bnd++; end
        repeat (10) @(negedge clk);
        checks++; if (a_rx.size() != base_rx + 4) begin
            failures++; $display("FAIL stream_count: got %0d bytes expected 4", a_rx.size() - base_rx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (a_rx[base_rx+i] !== v[i]) begin failures++; $display("FAIL stream_byte%0d: got %h expected %h", i, a_rx[base_rx+i], v[i]); end
            end
        end
        checks++; if (a_sync_t.size() != base_s + 4) begin
            failures++; $display("FAIL stream_syncs: got %0d expected 4", a_sync_t.size() - base_s);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++; if (a_sync_t[base_s+i] - a_sync_t[base_s+i-1] != 37) begin
                    failures++; $display("FAIL stream_period%0d: got %0d expected 37", i, a_sync_t[base_s+i] - a_sync_t[base_s+i-1]);
                end
            end
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        int bnd;
        @(negedge clk);
        a_in_data = d; a_in_valid = 1'b1;
        bnd = 0;
        while (!a_in_ready && bnd < 500) begin @(negedge clk); bnd++; end
        if (bnd >= 500) begin checks++; failures++; $display("FAIL send_timeout: got no in_ready expected accept of %h", d); end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic test_req_drop;
        int base_rx, s0, bnd, t, lat;
        base_rx = a_rx.size();
        send_a(8'h96);
        send_a(8'h69);
        bnd = 0;
        while (a_rx.size() == base_rx && bnd < 300) begin @(negedge clk); bnd++; end
        while (a_mp3_clk !== 1'b0 && bnd < 300) begin @(negedge clk); bnd++; end
        a_mp3_req = 1'b0;
        s0 = a_sync_t.size();
        repeat (50) @(negedge clk);
        checks++; if (a_sync_t.size() != s0) begin failures++; $display("FAIL req_low_sync: got %0d syncs expected 0", a_sync_t.size() - s0); end
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            failures++; $display("FAIL req_low_wait: got busy=%b ready=%b expected busy=0 ready=0", a_busy, a_in_ready);
        end
        a_mp3_req = 1'b1;
        t = cyc;
        bnd = 0;
        while (a_sync_t.size() == s0 && bnd < 20) begin @(negedge clk); bnd++; end
        lat = (a_sync_t.size() == s0) ? 99 : a_sync_t[s0] - t;
        checks++; if (lat < 1 || lat > 3) begin failures++; $display("FAIL req_rise_latency: got %0d expected 1..3", lat); end
        bnd = 0;
        while (a_rx.size() < base_rx + 2 && bnd < 300) begin @(negedge clk); bnd++; end
        checks++; if (a_rx.size() != base_rx + 2) begin
            failures++; $display("FAIL req_count: got %0d bytes expected 2", a_rx.size() - base_rx);
        end else begin
            checks++; if (a_rx[base_rx] !== 8'h96 || a_rx[base_rx+1] !== 8'h69) begin
                failures++; $display("FAIL req_bytes: got %h %h expected 96 69", a_rx[base_rx], a_rx[base_rx+1]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int base_rx, base_r, rxb, bnd, toggles;
        base_rx = a_rx.size(); base_r = a_rise_t.size();
        send_a(8'hC3);
        send_a(8'h7E);
        bnd = 0;
        while (a_rise_t.size() < base_r + 5 && bnd < 300) begin @(negedge clk); bnd++; end
        #2; rst_n = 1'b0;
        #1;
        checks++; if (a_mp3_clk !== 1'b0 || a_mp3_sync !== 1'b0 || a_mp3_data !== 1'b0) begin
            failures++; $display("FAIL midrst_serial: got clk=%b sync=%b data=%b expected 0 0 0", a_mp3_clk, a_mp3_sync, a_mp3_data);
        end
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_status: got busy=%b ready=%b expected busy=0 ready=1", a_busy, a_in_ready);
        end
        toggles = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (a_mp3_clk !== 1'b0) toggles++; end
        checks++; if (toggles != 0) begin failures++; $display("FAIL midrst_toggle: got %0d expected 0", toggles); end
        #1; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rxb = a_rx.size();
        checks++; if (rxb != base_rx) begin failures++; $display("FAIL midrst_partial: got %0d bytes expected 0", rxb - base_rx); end
        send_a(8'h81);
        bnd = 0;
        while ((a_rx.size() == rxb || a_busy) && bnd < 300) begin @(negedge clk); bnd++; end
        repeat (60) @(negedge clk);
        checks++; if (a_rx.size() != rxb + 1) begin
            failures++; $display("FAIL midrst_count: got %0d bytes expected 1", a_rx.size() - rxb);
        end else begin
            checks++; if (a_rx[rxb] !== 8'h81) begin failures++; $display("FAIL midrst_byte: got %h expected 81", a_rx[rxb]); end
        end
        checks++; if (a_stab != 0 || a_stray != 0) begin
            failures++; $display("FAIL midrst_protocol: got stab=%0d stray=%0d expected 0", a_stab, a_stray);
        end
    endtask

    task automatic test_random;
        int seen, bnd, n;
        bit pending;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    @(negedge clk);
                    b_in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    b_in_data = d; b_in_valid = 1'b1;
                    bnd = 0;
                    while (!b_in_ready && bnd < 400) begin @(negedge clk); bnd++; end
                    if (bnd >= 400) begin checks++; failures++; $display("FAIL rand_accept_timeout: got no in_ready expected byte %0d", i); end
                    b_exp.push_back(d);
                end
                @(negedge clk);
                b_in_valid = 1'b0;
                b_feed_done = 1'b1;
            end
            begin
                seen = b_rx.size(); pending = 1'b0;
                while (!b_feed_done) begin
                    @(negedge clk);
                    if (b_rx.size() != seen) begin seen = b_rx.size(); pending = 1'b1; end
                    if (pending && !b_mp3_clk) begin
                        pending = 1'b0;
                        if ($urandom_range(0, 4) == 0) begin
                            #1 b_mp3_req = 1'b0;
                            repeat ($urandom_range(1, 64)) @(negedge clk);
                            #1 b_mp3_req = 1'b1;
                            seen = b_rx.size();
                        end
                    end
                end
            end
        join
        bnd = 0;
        while ((b_rx.size() < b_exp.size() || b_busy) && bnd < 3000) begin @(negedge clk); bnd++; end
        checks++; if (b_rx.size() != b_exp.size()) begin
            failures++; $display("FAIL rand_count: got %0d bytes expected %0d", b_rx.size(), b_exp.size());
        end
        n = (b_rx.size() < b_exp.size()) ? b_rx.size() : b_exp.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (b_rx[i] !== b_exp[i]) begin failures++; $display("FAIL rand_byte%0d: got %h expected %h", i, b_rx[i], b_exp[i]); end
        end
        checks++; if (b_viol != 0 || b_stab != 0 || b_stray != 0) begin
            failures++; $display("FAIL rand_protocol: got viol=%0d stab=%0d stray=%0d expected 0", b_viol, b_stab, b_stray);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_single();
        test_stream();
        test_req_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
